// File: rtl/cozy_debug_pkg.sv
// Shared definitions for the register-file debug bridge: command opcodes,
// response codes, FSM state encoding and a small command decoder.
package cozy_debug_pkg;

  // High-nibble opcodes; the low nibble carries the register index.
  localparam logic [3:0] OP_READ       = 4'h1;
  localparam logic [3:0] OP_WRITE      = 4'h2;
  // The dump command is only recognised as the exact byte 0x30.
  localparam logic [7:0] CMD_DUMP_BYTE = 8'h30;

  // Response bytes that are not register data.
  localparam logic [7:0] RSP_ACK       = 8'hA5;
  localparam logic [7:0] RSP_TIMEOUT   = 8'hEE;
  localparam logic [7:0] RSP_BAD_CMD   = 8'hEF;

  // Dump walks R1..R15; R0 is hard-wired to zero and never dumped.
  localparam logic [3:0] DUMP_FIRST    = 4'd1;
  localparam logic [3:0] DUMP_LAST     = 4'd15;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HALT_WAIT,
    ST_GET_HI,
    ST_GET_LO,
    ST_COMMIT,
    ST_SEND_HI,
    ST_SEND_LO,
    ST_NEXT,
    ST_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    KIND_READ,
    KIND_WRITE,
    KIND_DUMP,
    KIND_BAD
  } cmd_kind_t;

  // Classify a command byte received while idle.
  function automatic cmd_kind_t decode_cmd(input logic [7:0] cmd);
    cmd_kind_t kind;
    if (cmd == CMD_DUMP_BYTE) begin
      kind = KIND_DUMP;
    end else if (cmd[7:4] == OP_READ) begin
      kind = KIND_READ;
    end else if (cmd[7:4] == OP_WRITE) begin
      kind = KIND_WRITE;
    end else begin
      kind = KIND_BAD;
    end
    return kind;
  endfunction

endpackage

// File: rtl/cozy_regfile_debug_if.sv
// Byte-wide host link: a command stream into the bridge and a response
// stream back out, each with its own valid/ready handshake.
interface cozy_regfile_debug_if;

  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       rsp_ready;

  // Host side: sends commands, accepts responses.
  modport master (
    output cmd_data,
    output cmd_valid,
    input  cmd_ready,
    input  rsp_data,
    input  rsp_valid,
    output rsp_ready
  );

  // Bridge side: accepts commands, sends responses.
  modport slave (
    input  cmd_data,
    input  cmd_valid,
    output cmd_ready,
    output rsp_data,
    output rsp_valid,
    input  rsp_ready
  );

endinterface

// File: rtl/cozy_regfile_debug.sv
// Debug bridge between a byte-oriented host link and the CPU register file.
// It halts the CPU, takes over the register-file ports, performs a single
// read, a single write or a dump of R1..R15, returns the result bytes and
// then hands the register file back to the CPU.
module cozy_regfile_debug
  import cozy_debug_pkg::*;
#(
  parameter int HALT_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  cozy_regfile_debug_if.slave        host,
  output logic                       halt_req,
  input  logic                       cpu_halted,
  output logic [3:0]                 rD_sel,
  output logic                       rD_we,
  output logic [15:0]                rD_in,
  output logic [3:0]                 rS_sel,
  input  logic [15:0]                rS_out
);

  localparam int CNT_W = (HALT_TIMEOUT < 1) ? 1 : $clog2(HALT_TIMEOUT + 1);

  state_t            state_q, state_d;
  cmd_kind_t         kind_q, kind_d;
  logic [3:0]        idx_q, idx_d;
  logic [15:0]       data_q, data_d;
  logic [15:0]       hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic [7:0]        code_q, code_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              cmd_fire;
  logic              rsp_fire;
  logic              halt_expired;

  assign cmd_fire     = host.cmd_valid && host.cmd_ready;
  assign rsp_fire     = rsp_valid_q && host.rsp_ready;
  assign cnt_inc      = cnt_q + 1'b1;
  assign halt_expired = (cnt_inc == CNT_W'(HALT_TIMEOUT));

  assign host.rsp_valid = rsp_valid_q;
  assign rD_sel         = idx_q;
  assign rD_in          = data_q;
  assign rS_sel         = idx_q;

  // State register; reset abandons any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: sequencing of halt, data capture, transfer and release.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          unique case (decode_cmd(host.cmd_data))
            KIND_READ, KIND_DUMP: state_d = ST_HALT_WAIT;
            KIND_WRITE:           state_d = ST_GET_HI;
            default:              state_d = ST_RELEASE;
          endcase
        end
      end
      ST_GET_HI: begin
        if (cmd_fire) state_d = ST_GET_LO;
      end
      ST_GET_LO: begin
        if (cmd_fire) state_d = ST_HALT_WAIT;
      end
      ST_HALT_WAIT: begin
        if (cpu_halted) begin
          state_d = (kind_q == KIND_WRITE) ? ST_COMMIT : ST_SEND_HI;
        end else if (halt_expired) begin
          state_d = ST_RELEASE;
        end
      end
      ST_COMMIT: begin
        state_d = ST_RELEASE;
      end
      ST_SEND_HI: begin
        if (rsp_fire) state_d = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        if (rsp_fire) begin
          if (kind_q == KIND_DUMP && idx_q != DUMP_LAST) begin
            state_d = ST_NEXT;
          end else begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_NEXT: begin
        state_d = ST_SEND_HI;
      end
      ST_RELEASE: begin
        if (!cpu_halted && !rsp_valid_q) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next-state: command latches, halt counter and response buffer.
  always_comb begin
    kind_d      = kind_q;
    idx_d       = idx_q;
    data_d      = data_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    rsp_valid_d = rsp_valid_q && !host.rsp_ready;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          kind_d = decode_cmd(host.cmd_data);
          idx_d  = (decode_cmd(host.cmd_data) == KIND_DUMP) ? DUMP_FIRST
                                                            : host.cmd_data[3:0];
          cnt_d  = '0;
          if (decode_cmd(host.cmd_data) == KIND_BAD) begin
            code_d      = RSP_BAD_CMD;
            rsp_valid_d = 1'b1;
          end
        end
      end
      ST_GET_HI: begin
        if (cmd_fire) data_d[15:8] = host.cmd_data;
      end
      ST_GET_LO: begin
        if (cmd_fire) begin
          data_d[7:0] = host.cmd_data;
          cnt_d       = '0;
        end
      end
      ST_HALT_WAIT: begin
        if (!cpu_halted) begin
          cnt_d = cnt_inc;
          if (halt_expired) begin
            code_d      = RSP_TIMEOUT;
            rsp_valid_d = 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        code_d      = RSP_ACK;
        rsp_valid_d = 1'b1;
      end
      ST_SEND_HI: begin
        if (!rsp_valid_q) begin
          hold_d      = rS_out;
          rsp_valid_d = 1'b1;
        end else if (host.rsp_ready) begin
          rsp_valid_d = 1'b1;
        end
      end
      ST_NEXT: begin
        idx_d = idx_q + 4'd1;
      end
      default: begin
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind_q      <= KIND_READ;
      idx_q       <= '0;
      data_q      <= '0;
      hold_q      <= '0;
      cnt_q       <= '0;
      code_q      <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      kind_q      <= kind_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Outputs decoded from state: ready, halt request, write strobe, response byte.
  always_comb begin
    host.cmd_ready = 1'b0;
    halt_req       = 1'b0;
    rD_we          = 1'b0;
    host.rsp_data  = code_q;
    unique case (state_q)
      ST_IDLE, ST_GET_HI, ST_GET_LO: begin
        host.cmd_ready = !rst;
      end
      ST_HALT_WAIT, ST_NEXT: begin
        halt_req = 1'b1;
      end
      ST_COMMIT: begin
        halt_req = 1'b1;
        rD_we    = cpu_halted;
      end
      ST_SEND_HI: begin
        halt_req      = 1'b1;
        host.rsp_data = hold_q[15:8];
      end
      ST_SEND_LO: begin
        halt_req      = 1'b1;
        host.rsp_data = hold_q[7:0];
      end
      default: begin
      end
    endcase
  end

endmodule
